// File: rtl/bus_drvr_port_if.sv
// bus_drvr_port_if
// Purpose: groups the host-side and bus-side signals of one bus_drvr_port
//          terminal adapter into one bundle.
// Signals:
//   host tx : tx_wr, tx_data -> tx_full, tx_count, tx_ovf
//   bus     : pop, push, D_push -> pndng, D_pop
//   host rx : rx_rd -> rx_vld, rx_data, rx_full, rx_ovf
//   status  : mis_cnt (saturating misroute count)
// Modports: slave = the port adapter itself, master = host/bus side driving it.
interface bus_drvr_port_if #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8
);
  localparam int cnt_w = $clog2(depth + 1);

  logic               tx_wr;
  logic [pckg_sz-1:0] tx_data;
  logic               tx_full;
  logic [cnt_w-1:0]   tx_count;
  logic               tx_ovf;

  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;

  logic               rx_rd;
  logic               rx_vld;
  logic [pckg_sz-1:0] rx_data;
  logic               rx_full;
  logic               rx_ovf;
  logic [7:0]         mis_cnt;

  modport slave (
    input  tx_wr, tx_data, pop, push, D_push, rx_rd,
    output tx_full, tx_count, tx_ovf, pndng, D_pop,
           rx_vld, rx_data, rx_full, rx_ovf, mis_cnt
  );

  modport master (
    output tx_wr, tx_data, pop, push, D_push, rx_rd,
    input  tx_full, tx_count, tx_ovf, pndng, D_pop,
           rx_vld, rx_data, rx_full, rx_ovf, mis_cnt
  );
endinterface

// File: rtl/bus_drvr_port.sv
// bus_drvr_port
// Purpose: per-terminal adapter between a host and one terminal slot of the
//          bus generator/arbiter. A tx FIFO feeds the bus (pndng/D_pop/pop),
//          an ID-filtered rx FIFO captures bus deliveries (push/D_push).
//          Sticky overflow flags and a saturating misroute counter report
//          dropped or misaddressed traffic.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-low
//   bus   : bus_drvr_port_if.slave (host tx/rx strobes, bus pop/push, status)
// Parameters: pckg_sz (packet width, ID in top 8 bits), depth (power of 2),
//             id (this terminal), broadcast (ID accepted by all terminals).
module bus_drvr_port #(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'h00,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input logic clk,
  input logic reset,
  bus_drvr_port_if.slave bus
);

  localparam int ptr_w = $clog2(depth);
  localparam int cnt_w = $clog2(depth + 1);
  localparam logic [cnt_w-1:0] full_cnt = cnt_w'(depth);

  // ---------------- tx FIFO ----------------
  logic [pckg_sz-1:0] tx_mem [depth];
  logic [ptr_w-1:0]   tx_rd_ptr, tx_wr_ptr;
  logic [cnt_w-1:0]   tx_cnt;
  logic               tx_ovf_q;
  logic               tx_empty, tx_is_full, tx_pop_eff, tx_wr_eff;

  assign tx_empty   = (tx_cnt == '0);
  assign tx_is_full = (tx_cnt == full_cnt);
  assign tx_pop_eff = bus.pop && !tx_empty;
  // A write into a full FIFO still lands if the head leaves in the same cycle.
  assign tx_wr_eff  = bus.tx_wr && (!tx_is_full || tx_pop_eff);

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_rd_ptr <= '0;
      tx_wr_ptr <= '0;
      tx_cnt    <= '0;
      tx_ovf_q  <= 1'b0;
    end else begin
      if (tx_wr_eff)
        tx_wr_ptr <= tx_wr_ptr + ptr_w'(1);
      if (tx_pop_eff)
        tx_rd_ptr <= tx_rd_ptr + ptr_w'(1);
      case ({tx_wr_eff, tx_pop_eff})
        2'b10:   tx_cnt <= tx_cnt + cnt_w'(1);
        2'b01:   tx_cnt <= tx_cnt - cnt_w'(1);
        default: tx_cnt <= tx_cnt;
      endcase
      if (bus.tx_wr && !tx_wr_eff)
        tx_ovf_q <= 1'b1;
    end
  end

  // Storage needs no reset: contents are invisible while the count is zero.
  always_ff @(posedge clk) begin
    if (reset && tx_wr_eff)
      tx_mem[tx_wr_ptr] <= bus.tx_data;
  end

  assign bus.pndng    = !tx_empty;
  assign bus.D_pop    = tx_empty ? '0 : tx_mem[tx_rd_ptr];
  assign bus.tx_full  = tx_is_full;
  assign bus.tx_count = tx_cnt;
  assign bus.tx_ovf   = tx_ovf_q;

  // ---------------- rx FIFO with ID filter ----------------
  logic [pckg_sz-1:0] rx_mem [depth];
  logic [ptr_w-1:0]   rx_rd_ptr, rx_wr_ptr;
  logic [cnt_w-1:0]   rx_cnt;
  logic               rx_ovf_q;
  logic [7:0]         mis_q;
  logic [7:0]         dest;
  logic               id_hit, rx_empty, rx_is_full, rx_rd_eff, rx_st_eff;

  assign dest       = bus.D_push[pckg_sz-1 -: 8];
  assign id_hit     = bus.push && ((dest == id) || (dest == broadcast));
  assign rx_empty   = (rx_cnt == '0);
  assign rx_is_full = (rx_cnt == full_cnt);
  assign rx_rd_eff  = bus.rx_rd && !rx_empty;
  assign rx_st_eff  = id_hit && (!rx_is_full || rx_rd_eff);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_cnt    <= '0;
      rx_ovf_q  <= 1'b0;
      mis_q     <= '0;
    end else begin
      if (rx_st_eff)
        rx_wr_ptr <= rx_wr_ptr + ptr_w'(1);
      if (rx_rd_eff)
        rx_rd_ptr <= rx_rd_ptr + ptr_w'(1);
      case ({rx_st_eff, rx_rd_eff})
        2'b10:   rx_cnt <= rx_cnt + cnt_w'(1);
        2'b01:   rx_cnt <= rx_cnt - cnt_w'(1);
        default: rx_cnt <= rx_cnt;
      endcase
      // Only packets addressed to us count as overflow; misroutes go to mis_q.
      if (id_hit && !rx_st_eff)
        rx_ovf_q <= 1'b1;
      if (bus.push && !id_hit && (mis_q != 8'hFF))
        mis_q <= mis_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && rx_st_eff)
      rx_mem[rx_wr_ptr] <= bus.D_push;
  end

  assign bus.rx_vld  = !rx_empty;
  assign bus.rx_data = rx_empty ? '0 : rx_mem[rx_rd_ptr];
  assign bus.rx_full = rx_is_full;
  assign bus.rx_ovf  = rx_ovf_q;
  assign bus.mis_cnt = mis_q;

endmodule

// File: doc/bus_drvr_port.md
# bus_drvr_port

Per-terminal port adapter that sits directly on one of the `drvrs` terminal slots of `bs_gnrtr_n_rbtr`. Toward the bus it is the terminal-side FIFO: it presents `pndng`/`D_pop` and consumes `pop`, and it captures `push`/`D_push` deliveries. Toward the host it offers a transmit FIFO and an ID-filtered receive FIFO. It also provides sticky overflow flags and a saturating misroute counter.

## Interface
- `pckg_sz`, 16: packet width in bits; minimum 9. Bits `[pckg_sz-1 -: 8]` hold the destination ID.
- `depth`, 8: entries per FIFO (tx and rx independently); power of 2, minimum 2.
- `id`, 0: this terminal's 8-bit ID.
- `broadcast`, 8'hFF: ID value accepted by every terminal.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `tx_wr`  in  1  host write strobe into the tx FIFO.
- `tx_data`  in  pckg_sz  packet to transmit.
- `tx_full`  out  1  tx FIFO holds `depth` entries.
- `tx_count`  out  $clog2(depth+1)  tx occupancy.
- `tx_ovf`  out  1  sticky: a tx write was dropped.
- `pndng`  out  1  tx FIFO non-empty; goes to the bus `pndng[0][n]`.
- `D_pop`  out  pckg_sz  tx head (show-ahead); goes to the bus `D_pop[0][n]`.
- `pop`  in  1  bus consumes the head.
- `push`  in  1  bus delivers a packet.
- `D_push`  in  pckg_sz  delivered packet.
- `rx_rd`  in  1  host read strobe.
- `rx_vld`  out  1  rx FIFO non-empty.
- `rx_data`  out  pckg_sz  rx head (show-ahead).
- `rx_full`  out  1  rx FIFO holds `depth` entries.
- `rx_ovf`  out  1  sticky: an accepted-ID packet was dropped.
- `mis_cnt`  out  8  count of pushes whose ID matched neither `id` nor `broadcast`; saturates at 255.

## Operation
- **Two circular FIFOs.** Each uses read and write pointers of width $clog2(depth) that wrap modulo `depth`, plus an occupancy counter of width $clog2(depth+1). Full is count==depth; empty is count==0.
- **Tx write.** Accepted when `tx_wr` and (not full, or full with an effective pop in the same cycle). `tx_wr` while full with no pop: data dropped, `tx_ovf` set; it stays set until reset.
- **Tx pop.** Effective only when `pop` and `pndng`. `pop` while empty is ignored and causes no error.
- **Simultaneous tx write and pop.**
  - Non-empty: both happen and count is unchanged.
  - Empty: the write is taken, the pop is ignored, and count becomes 1.
- **Rx filter.** On `push`, compare `D_push[pckg_sz-1 -: 8]` against `id` and `broadcast`.
  - Match: store the packet if rx is not full, or if it is full and an effective `rx_rd` occurs in the same cycle. Otherwise drop it and set `rx_ovf` (sticky).
  - No match: increment `mis_cnt`, saturating at 255. Nothing is stored and `rx_ovf` is not affected.
- **Rx read.** Effective only when `rx_rd` and `rx_vld`; otherwise ignored. Simultaneous store and read follows the same rules as tx.
- **Data outputs.** `D_pop` and `rx_data` are forced to 0 while the corresponding FIFO is empty.
- **Reset.** Sampling `reset`==0 at an edge discards all contents and resets pointers, counts, flags and `mis_cnt`. This applies mid-operation as well: strobes in the reset cycle are ignored.

## Timing
- **Reset values:** `pndng`=0, `D_pop`=0, `tx_full`=0, `tx_count`=0, `tx_ovf`=0, `rx_vld`=0, `rx_data`=0, `rx_full`=0, `rx_ovf`=0, `mis_cnt`=0.
- **Write-to-visible latency is 1 cycle.** A write at edge k gives `pndng`=1 (or `rx_vld`=1) with data on `D_pop`/`rx_data` after edge k.
- **Pop/read.** A pop or read at edge k presents the next head, or 0 if empty, after edge k. The bus may pop on consecutive cycles.
- **Derived outputs.** Flags, counts and data outputs are pure functions of registered state: no combinational path from any input strobe to any output.
- **Counter timing.** `mis_cnt` and the overflow flags update at the same edge as the offending strobe.

## Test plan
- **Reset then single packet:** reset low for 2 cycles, then write 16'h03A5 → `pndng`=1 and `D_pop`=16'h03A5 one cycle later; one `pop` → `pndng`=0, `D_pop`=0.
- **Fill and overflow:** write 8 packets 16'h0100..16'h0107, then a 9th (16'h0108) with no pop → `tx_full`=1, `tx_count`=8, `tx_ovf`=1; eight pops return 0100..0107 in order with wrap intact.
- **Full with simultaneous write and pop:** full FIFO, `tx_wr`(16'h0155)+`pop` in the same cycle → head advances, count stays 8, `tx_ovf` stays 0, and 16'h0155 appears last.
- **Rx filter with `id`=3:** push 16'h03AA, 16'hFFBB, 16'h05CC → rx holds AA then BB, `mis_cnt`=1; 300 pushes of 16'h0700 → `mis_cnt`=255.
- **Rx overflow:** 8 matching pushes fill rx, then a 9th with no `rx_rd` → `rx_ovf`=1 and the stored contents are unchanged.
- **Reset mid-operation:** with 4 tx and 2 rx entries held, drive `reset` low for one edge together with `tx_wr` and `push` → all outputs return to reset values and the strobes are not stored.
